p2s_rr_sched: RTL and testbench

Round-robin scheduler that shares one parallel-to-serial shifter among N requesters. Each requester presents a W-bit word and holds a request. The block grants one requester at a time, captures its word and serialises it LSB-first with frame markers. It sits between several word-producing clients and a single serial output lane, and replaces per-client serialisers.

---
 rtl/p2s_rr_sched.sv | 163 ++++++++++++++++
 tb/tb_p2s_rr_sched.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/p2s_rr_sched.sv
// Round-robin scheduler sharing one LSB-first parallel-to-serial shifter among N requesters.
// grant is combinational in arbitration slots; all other outputs are registered.
module p2s_rr_sched #(
  parameter  int N   = 4,
  parameter  int W   = 8,
  parameter  int GAP = 0,
  localparam int IW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  data,
  output logic [N-1:0]    grant,
  output logic            sout,
  output logic            sout_valid,
  output logic            frame_start,
  output logic            frame_end,
  output logic [IW-1:0]   cur_id,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  localparam int             CW       = (W > 1) ? $clog2(W) : 1;
  localparam int             CAW      = IW + 1;
  localparam logic [CW-1:0]  BIT_LAST = CW'(W - 1);
  localparam logic [3:0]     GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam logic [IW-1:0]  ID_LAST  = IW'(N - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [CW-1:0]   bit_q, bit_d;
  logic [3:0]      gap_q, gap_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   cur_id_q, cur_id_d;
  logic            sout_q, sout_d;
  logic            valid_q, valid_d;
  logic            fs_q, fs_d;
  logic            fe_q, fe_d;
  logic            busy_q, busy_d;

  logic            slot_s;
  logic            found_s;
  logic [IW-1:0]   win_s;
  logic [CAW-1:0]  cand_s;
  logic [W-1:0]    word_s;
  logic [N-1:0]    grant_s;

  // Rotating priority search: first requester at or after ptr, wrapping modulo N.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    cand_s  = '0;
    for (int k = 0; k < N; k++) begin
      cand_s  = {1'b0, ptr_q} + CAW'(k);
      cand_s  = (cand_s >= CAW'(N)) ? (cand_s - CAW'(N)) : cand_s;
      win_s   = (!found_s && req[cand_s[IW-1:0]]) ? cand_s[IW-1:0] : win_s;
      found_s = found_s | req[cand_s[IW-1:0]];
    end
  end

  // Arbitration slot: any idle cycle, or the final cycle of the frame/gap sequence.
  always_comb begin
    case (state_q)
      S_IDLE:  slot_s = 1'b1;
      S_SHIFT: slot_s = (GAP == 0) && (bit_q == BIT_LAST);
      S_GAP:   slot_s = (gap_q == GAP_LAST);
      default: slot_s = 1'b1;
    endcase
  end

  // Combinational one-hot grant and winner word selection.
  always_comb begin
    grant_s        = '0;
    grant_s[win_s] = slot_s & found_s;
    word_s         = data[win_s*W +: W];
  end

  // Next-state for the sequencer, shifter, counters and round-robin pointer.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    ptr_d    = ptr_q;
    cur_id_d = cur_id_q;
    if (slot_s && found_s) begin
      state_d  = S_SHIFT;
      shift_d  = word_s;
      bit_d    = '0;
      gap_d    = 4'd0;
      cur_id_d = win_s;
      ptr_d    = (win_s == ID_LAST) ? '0 : (win_s + IW'(1));
    end else if (slot_s) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_SHIFT: begin
          if (bit_q == BIT_LAST) begin
            state_d = S_GAP;
            gap_d   = 4'd0;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + CW'(1);
          end
        end
        S_GAP:   gap_d   = gap_q + 4'd1;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are computed from the next state so they can be registered without adding latency.
  always_comb begin
    valid_d = (state_d == S_SHIFT);
    sout_d  = valid_d & shift_d[0];
    fs_d    = valid_d && (bit_d == '0);
    fe_d    = valid_d && (bit_d == BIT_LAST);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      bit_q    <= '0;
      gap_q    <= 4'd0;
      ptr_q    <= '0;
      cur_id_q <= '0;
      sout_q   <= 1'b0;
      valid_q  <= 1'b0;
      fs_q     <= 1'b0;
      fe_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      ptr_q    <= ptr_d;
      cur_id_q <= cur_id_d;
      sout_q   <= sout_d;
      valid_q  <= valid_d;
      fs_q     <= fs_d;
      fe_q     <= fe_d;
      busy_q   <= busy_d;
    end
  end

  assign grant       = grant_s;
  assign sout        = sout_q;
  assign sout_valid  = valid_q;
  assign frame_start = fs_q;
  assign frame_end   = fe_q;
  assign cur_id      = cur_id_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_p2s_rr_sched.sv
// Bench for p2s_rr_sched: GAP=0 and GAP=2 instances checked every cycle against a
// queue-based frame model, plus directed scenarios with hand-computed expectations.
module tb_p2s_rr_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_a = 4'd0, req_b = 4'd0;
  logic [31:0] data_a, data_b;
  logic [3:0]  gnt_a, gnt_b;
  logic        sout_a, vld_a, fs_a, fe_a, busy_a;
  logic        sout_b, vld_b, fs_b, fe_b, busy_b;
  logic [1:0]  id_a, id_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  p2s_rr_sched #(.N(4), .W(8), .GAP(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .data(data_a), .grant(gnt_a),
    .sout(sout_a), .sout_valid(vld_a), .frame_start(fs_a), .frame_end(fe_a),
    .cur_id(id_a), .busy(busy_a));

  p2s_rr_sched #(.N(4), .W(8), .GAP(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .data(data_b), .grant(gnt_b),
    .sout(sout_b), .sout_valid(vld_b), .frame_start(fs_b), .frame_end(fe_b),
    .cur_id(id_b), .busy(busy_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every granted frame becomes W output entries plus GAP idle-but-busy entries.
  typedef struct packed {
    logic       v;
    logic       s;
    logic       fs;
    logic       fe;
    logic [1:0] id;
    logic       busy;
  } ent_t;

  ent_t m_rb [2][32];
  ent_t m_cur [2];
  int   m_rd [2];
  int   m_n [2];
  int   m_ptr [2];
  int   m_last [2];

  task automatic step_unit(input int u, input int gap, input logic [3:0] r,
                           input logic [31:0] dv, input logic [6:0] act, input logic [3:0] g);
    int         win;
    logic [7:0] w;
    logic [3:0] eg;
    ent_t       e;
    if (!rst_n) begin
      m_ptr[u] = 0; m_last[u] = 0; m_n[u] = 0; m_rd[u] = 0; m_cur[u] = '0;
    end
    chk(u == 0 ? "A_outputs" : "B_outputs", 32'(act), 32'(m_cur[u]));
    win = -1;
    if (m_n[u] == 0) begin
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = (m_ptr[u] + k) % 4;
        if (win < 0 && r[idx]) win = idx;
      end
    end
    eg = (win >= 0) ? (4'd1 << win) : 4'd0;
    chk(u == 0 ? "A_grant" : "B_grant", 32'(g), 32'(eg));
    if (rst_n) begin
      if (win >= 0) begin
        w = 8'(dv >> (win * 8));
        for (int i = 0; i < 8 + gap; i++) begin
          e.v    = (i < 8);
          e.s    = (i < 8) ? w[i] : 1'b0;
          e.fs   = (i == 0);
          e.fe   = (i == 7);
          e.id   = 2'(win);
          e.busy = 1'b1;
          m_rb[u][(m_rd[u] + m_n[u]) % 32] = e;
          m_n[u]++;
        end
        m_ptr[u]  = (win + 1) % 4;
        m_last[u] = win;
      end
      if (m_n[u] > 0) begin
        m_cur[u] = m_rb[u][m_rd[u]];
        m_rd[u]  = (m_rd[u] + 1) % 32;
        m_n[u]--;
      end else begin
        m_cur[u] = '{v: 1'b0, s: 1'b0, fs: 1'b0, fe: 1'b0, id: 2'(m_last[u]), busy: 1'b0};
      end
    end
  endtask

  // Compare process: both instances against the model on every falling edge.
  always @(negedge clk) begin
    step_unit(0, 0, req_a, data_a, {vld_a, sout_a, fs_a, fe_a, id_a, busy_a}, gnt_a);
    step_unit(1, 2, req_b, data_b, {vld_b, sout_b, fs_b, fe_b, id_b, busy_b}, gnt_b);
  end

  task automatic collect_a(output logic [7:0] w, output logic [1:0] fsfe, output logic [1:0] id);
    fsfe = 2'b00;
    id   = 2'b00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      w[i] = sout_a;
      if (i == 0) begin fsfe[1] = fs_a; id = id_a; end
      if (i == 7) fsfe[0] = fe_a;
    end
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  w;
    logic [1:0]  fsfe, id;
    logic [19:0] glog;
    logic [3:0]  or_g;
    int ng, run, maxrun, cnt, st, gapcnt, seen;
    bit dropped;

    data_a = {8'h81, 8'h0F, 8'h3C, 8'hA5};
    data_b = {8'h81, 8'h0F, 8'h3C, 8'hA5};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'({sout_a, vld_a, fs_a, fe_a, busy_a, id_a, gnt_a}), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single request from requester 0
    @(posedge clk); #1 req_a = 4'b0001;
    @(negedge clk); chk("single_grant", 32'(gnt_a), 32'h1);
    @(posedge clk); #1 req_a = 4'b0000;
    collect_a(w, fsfe, id);
    chk("single_word", 32'(w), 32'hA5);
    chk("single_fs_fe", 32'(fsfe), 32'h3);
    chk("single_cur_id", 32'(id), 32'h0);
    @(negedge clk); chk("single_idle", 32'({busy_a, vld_a}), 32'h0);

    // All four requesting continuously from a fresh pointer
    reset_pulse();
    @(posedge clk); #1 req_a = 4'b1111;
    ng = 0; run = 0; maxrun = 0; glog = 20'h0; dropped = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      run    = vld_a ? run + 1 : 0;
      maxrun = (run > maxrun) ? run : maxrun;
      if (gnt_a != 4'd0 && ng < 5) begin
        for (int i = 0; i < 4; i++) if (gnt_a[i]) glog = {glog[15:0], 4'(i)};
        ng++;
      end
      if (ng == 5 && !dropped) begin
        @(posedge clk); #1 req_a = 4'b0000;
        dropped = 1'b1;
      end
    end
    chk("rr_grant_order", 32'(glog), 32'h01230);
    chk("rr_valid_run", 32'(maxrun), 32'd40);

    // Pointer fairness: after granting 2, search starts at 3 and wraps to 0
    @(posedge clk); #1 req_a = 4'b0100;
    @(negedge clk); chk("fair_grant2", 32'(gnt_a), 32'h4);
    @(posedge clk); #1 req_a = 4'b0101;
    seen = 0; cnt = 0;
    while (seen == 0 && cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (gnt_a != 4'd0) begin
        seen = cnt;
        chk("fair_grant0", 32'(gnt_a), 32'h1);
      end
    end
    chk("fair_slot_cycle", 32'(seen), 32'd8);
    @(posedge clk); #1 req_a = 4'b0000;
    repeat (10) @(posedge clk);

    // Gap insertion on the GAP=2 instance
    #1 req_b = 4'b0011;
    ng = 0; st = 0; gapcnt = 0; dropped = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (st == 0 && fe_b) begin
        st = 1; gapcnt = 0;
      end else if (st == 1) begin
        if (fs_b) begin
          st = 2;
          chk("gap_count", 32'(gapcnt), 32'd2);
          chk("gap_next_id", 32'(id_b), 32'd1);
        end else if (!vld_b) begin
          gapcnt++;
        end
      end
      if (gnt_b != 4'd0) ng++;
      if (ng == 2 && !dropped) begin
        @(posedge clk); #1 req_b = 4'b0000;
        dropped = 1'b1;
      end
    end
    chk("gap_seen", 32'(st), 32'd2);

    // Withdrawal: req[1] pulses mid-frame and is gone before the slot
    @(posedge clk); #1 req_a = 4'b0001;
    @(negedge clk); chk("wd_grant0", 32'(gnt_a), 32'h1);
    @(posedge clk); #1 req_a = 4'b0000;
    or_g = 4'd0;
    repeat (2) begin @(negedge clk); or_g |= gnt_a; @(posedge clk); #1; end
    req_a = 4'b0010;
    @(negedge clk); or_g |= gnt_a; @(posedge clk); #1 req_a = 4'b0000;
    repeat (10) begin @(negedge clk); or_g |= gnt_a; @(posedge clk); #1; end
    chk("wd_no_grant", 32'(or_g), 32'h0);
    @(negedge clk); chk("wd_idle", 32'({busy_a, vld_a}), 32'h0);

    // Reset mid-frame at bit 3 of requester 2's frame
    @(posedge clk); #1 req_a = 4'b0100;
    @(posedge clk); #1 req_a = 4'b0000;
    repeat (3) @(posedge clk);
    #1 chk("rst_pre_busy", 32'({busy_a, vld_a, id_a}), 32'h0E);
    #1 rst_n = 1'b0;
    #1 chk("rst_async", 32'({sout_a, vld_a, fs_a, fe_a, busy_a, id_a, gnt_a}), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1; req_a = 4'b1000;
    @(negedge clk); chk("rst_post_grant", 32'(gnt_a), 32'h8);
    @(posedge clk); #1 req_a = 4'b0000;
    collect_a(w, fsfe, id);
    chk("rst_post_word", 32'(w), 32'h81);
    chk("rst_post_fs_fe", 32'(fsfe), 32'h3);
    chk("rst_post_id", 32'(id), 32'h3);

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
